mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit for the single-cycle MIPS core. It consumes the two register-file read ports (rd1 → a, rd2 → b) and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. Results go into private HI/LO registers, which the core reads for MFHI/MFLO. The core stalls on `busy` while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch request; sampled only in IDLE.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6–7 reserved (treated as no-op).
- a  in  WIDTH  operand A (rs; dividend or multiplicand, or MTHI/MTLO data).
- b  in  WIDTH  operand B (rt; divisor or multiplier).
- flush  in  1  abort the in-flight operation; HI/LO are left unchanged.
- busy  out  1  operation in progress; core must stall any MFHI/MFLO/MDU op.
- done  out  1  one-cycle pulse when HI/LO were just updated by MULT/MULTU/DIV/DIVU.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + start with op 0/1:
  - Latch |a| and |b| (signed op) or a and b (unsigned op).
  - Latch result sign = a[31]^b[31] (signed only).
  - Clear the 64-bit accumulator; go to MUL.
- MUL: shift-add, 1 multiplier bit per cycle, 32 cycles, then go to FIX.
- IDLE + start with op 2/3:
  - Latch magnitudes as for multiply, plus the quotient sign and remainder sign (= dividend sign); go to DIV.
- DIV: restoring division, 1 quotient bit per cycle, 32 cycles, then go to FIX.
- FIX:
  - Multiply: negate the 64-bit product if the sign is set.
  - Divide: negate the quotient and/or remainder per their latched signs.
  - Write {hi,lo} (multiply) or hi=remainder, lo=quotient (divide); pulse done; return to IDLE.
- MTHI/MTLO: in IDLE with start, write hi (or lo) = a at that edge. No busy, no done.
- Reserved op with start: ignored; state stays IDLE.
- start while busy: ignored. The core guarantees it via the stall, but the RTL must not latch it.
- Divide by zero (b==0), any signedness: lo=32'hFFFF_FFFF, hi=a.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- Arithmetic: 64-bit accumulator; iteration counter is 6 bits; product width is exactly 2*WIDTH, no truncation.

## Timing
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset wins over start and flush in the same cycle.
- Launch: start sampled at edge E0; busy=1 from the cycle after E0.
- Busy duration: exactly 33 cycles (32 iterate + 1 FIX).
- Completion: the edge that leaves FIX writes hi/lo and sets done=1 for one cycle, with busy=0 in that same cycle.
- Back-to-back: total latency E0 → done is 34 cycles. A new start is accepted in the done cycle.
- MTHI/MTLO: hi/lo visible the cycle after the start edge.
- flush in MUL/DIV/FIX: next state IDLE, busy=0 next cycle, no done, hi/lo unchanged.
- flush in IDLE: no effect; flush with start in IDLE drops the start.
- Reset mid-operation: same as reset from idle; no done pulse.

## Configuration
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational 64-bit multiply.
  - hi/lo are written at the start edge, done pulses the next cycle, busy never asserts for multiply.
  - Divide timing is unchanged.
- MDU_FAST_MUL_EN undefined: the iterative 34-cycle multiply described above.

## Structure
- Shared include file (same style as the register-name include): op encodings (MDU_MULT … MDU_MTLO), state encodings, iteration count constant (32).
- One sub-module, `mdu_div_iter`: restoring divider datapath. It takes magnitudes and a start, and returns quotient/remainder after 32 steps. The sign fix-up and FSM stay in the top.

## Test plan
- MULT a=32'hFFFF_FFFE (-2), b=3 → after 34 cycles hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done pulse 1 cycle, busy high 33 cycles.
- MULTU a=b=32'hFFFF_FFFF → hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV a=-7, b=2 → lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU a=7, b=0 → lo=32'hFFFF_FFFF, hi=7.
- MTHI a=32'h1234_5678 then MTLO a=32'h9ABC_DEF0 on consecutive cycles → hi/lo set, busy never 1, no done.
- DIV started; flush at cycle 10 → busy low next cycle, hi/lo keep prior values, no done. A new MULT 5×6 then yields lo=30, hi=0.
- Reset asserted at cycle 20 of a DIV → hi=lo=0, busy=0; a start in the reset cycle is ignored.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op encodings, FSM states and iteration count for the multiply/divide unit
package mul_div_unit_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [5:0] MDU_ITER = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// rtl/mul_div_unit_div_iter.sv - unsigned restoring divider datapath, one quotient bit per step
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
    assign shifted = {remainder, quotient[WIDTH-1]};
    assign fits    = shifted >= {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
        end else if (step) begin
            quotient  <= {quotient[WIDTH-2:0], fits};
            remainder <= fits ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with private HI/LO
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply; divide stays iterative.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state, nxt;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   a_save;
    logic               sign_p, sign_r, div0, is_div;
    logic               launch, is_mul_op, is_div_op, signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   quo, rem;

    assign launch    = (state == ST_IDLE) && start && !flush;
    assign is_mul_op = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != ST_IDLE);

    // acc holds {partial product, unconsumed multiplier bits}; add mcand into the top half when bit0 set
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{WIDTH{signed_op & a[WIDTH-1]}}, a};
    assign ext_b     = {{WIDTH{signed_op & b[WIDTH-1]}}, b};
    assign fast_prod = ext_a * ext_b;
`endif

    mdu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (launch && is_div_op),
        .step      (state == ST_DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (launch && is_div_op) nxt = ST_DIV;
`ifndef MDU_FAST_MUL_EN
                if (launch && is_mul_op) nxt = ST_MUL;
`endif
            end
            ST_MUL, ST_DIV: begin
                if (flush)                  nxt = ST_IDLE;
                else if (cnt == MDU_ITER - 6'd1) nxt = ST_FIX;
            end
            ST_FIX:  nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            a_save <= '0;
            sign_p <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (launch) begin
                    cnt    <= '0;
                    sign_p <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_r <= signed_op && a[WIDTH-1];
                    is_div <= is_div_op;
                    div0   <= (b == '0);
                    a_save <= a;
                    case (op)
`ifdef MDU_FAST_MUL_EN
                        MDU_MULT, MDU_MULTU: begin
                            {hi, lo} <= fast_prod;
                            done     <= 1'b1;
                        end
`else
                        MDU_MULT, MDU_MULTU: begin
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                            mcand <= mag_a;
                        end
`endif
                        MDU_MTHI: hi <= a;
                        MDU_MTLO: lo <= a;
                        default: ;
                    endcase
                end
                ST_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 6'd1;
                end
                ST_DIV: cnt <= cnt + 6'd1;
                ST_FIX: if (!flush) begin
                    done <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= sign_p ? -acc : acc;
                    end else if (div0) begin
                        hi <= a_save;
                        lo <= '1;
                    end else begin
                        hi <= sign_r ? -rem : rem;
                        lo <= sign_p ? -quo : quo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
